// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, grant owner and a small sizing helper.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_RD_ZERO
   } arb_state_e;

   typedef enum logic {
      G_WR,
      G_RD
   } grant_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one external SRAM between a write requester and a read requester,
// with programmable access wait cycles and a recorded-length (high-water mark) tracker.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned WR_CYC = 2,
   parameter int unsigned RD_CYC = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ack,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_valid,
   output logic [ADDR_W:0]   o_rec_len,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_dq,
   output logic              o_sram_dq_oe,
   input  logic [DATA_W-1:0] i_sram_dq,
   output logic              o_sram_we_n,
   output logic              o_sram_oe_n
);

   localparam int unsigned LenW = ADDR_W + 1;
   localparam int unsigned CntW = $clog2(max_u(WR_CYC, RD_CYC) + 1);
   localparam logic [CntW-1:0] WrLast = CntW'(WR_CYC - 1);
   localparam logic [CntW-1:0] WrDone = CntW'(WR_CYC);
   localparam logic [CntW-1:0] RdLast = CntW'(RD_CYC - 1);

   arb_state_e        state_q;
   grant_e            last_grant_q;
   logic [CntW-1:0]   cnt_q;
   logic              wr_ack_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;
   logic [LenW-1:0]   rec_len_q;
   logic [LenW-1:0]   rec_len_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] dq_q;
   logic              dq_oe_q;
   logic              we_n_q;
   logic              oe_n_q;

   logic wr_elig;
   logic rd_elig;
   logic grant_wr;
   logic grant_rd;
   logic rd_beyond;
   logic commit;

   always_comb begin
      wr_elig   = i_wr_req;
      // The reader still holds its request during the valid pulse; that is not a new request.
      rd_elig   = i_rd_req && !rd_valid_q;
      grant_wr  = wr_elig && (!rd_elig || (last_grant_q == G_RD));
      grant_rd  = rd_elig && !grant_wr;
      rd_beyond = ({1'b0, i_rd_addr} >= rec_len_q);
      commit    = (state_q == S_WRITE) && wr_ack_q;
   end

   always_comb begin
      rec_len_d = rec_len_q;
      if (i_clear) begin
         rec_len_d = '0;
      end else if (commit && ({1'b0, addr_q} >= rec_len_q)) begin
         rec_len_d = {1'b0, addr_q} + LenW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= G_RD;
         cnt_q        <= '0;
         wr_ack_q     <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
         rec_len_q    <= '0;
         addr_q       <= '0;
         dq_q         <= '0;
         dq_oe_q      <= 1'b0;
         we_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
      end else begin
         wr_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rec_len_q  <= rec_len_d;
         unique case (state_q)
            S_IDLE: begin
               if (grant_wr) begin
                  state_q      <= S_WRITE;
                  last_grant_q <= G_WR;
                  addr_q       <= i_wr_addr;
                  dq_q         <= i_wr_data;
                  dq_oe_q      <= 1'b1;
                  we_n_q       <= 1'b0;
                  cnt_q        <= '0;
               end else if (grant_rd) begin
                  last_grant_q <= G_RD;
                  cnt_q        <= '0;
                  if (rd_beyond) begin
                     state_q <= S_RD_ZERO;
                  end else begin
                     state_q <= S_READ;
                     addr_q  <= i_rd_addr;
                     oe_n_q  <= 1'b0;
                  end
               end
            end
            S_WRITE: begin
               // Address and data stay driven for one cycle after WE_N rises.
               if (cnt_q == WrDone) begin
                  state_q <= S_IDLE;
                  dq_oe_q <= 1'b0;
               end else begin
                  if (cnt_q == WrLast) begin
                     we_n_q   <= 1'b1;
                     wr_ack_q <= 1'b1;
                  end
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            S_READ: begin
               if (cnt_q == RdLast) begin
                  state_q    <= S_IDLE;
                  oe_n_q     <= 1'b1;
                  rd_data_q  <= i_sram_dq;
                  rd_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            S_RD_ZERO: begin
               state_q    <= S_IDLE;
               rd_data_q  <= '0;
               rd_valid_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_wr_ack     = wr_ack_q;
   assign o_rd_valid   = rd_valid_q;
   assign o_rd_data    = rd_data_q;
   assign o_rec_len    = rec_len_q;
   assign o_sram_addr  = addr_q;
   assign o_sram_dq    = dq_q;
   assign o_sram_dq_oe = dq_oe_q;
   assign o_sram_we_n  = we_n_q;
   assign o_sram_oe_n  = oe_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a small behavioural SRAM model.
module tb_sram_port_arbiter;

   logic        clk;
   logic        rst;
   logic        clear;
   logic        wr_req;
   logic [19:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic        rd_req;
   logic [19:0] rd_addr;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [20:0] rec_len;
   logic [19:0] sram_addr;
   logic [15:0] sram_dq;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        we_n;
   logic        oe_n;

   int checks = 0;
   int errors = 0;

   sram_port_arbiter #(
      .ADDR_W(20),
      .DATA_W(16),
      .WR_CYC(2),
      .RD_CYC(2)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_clear     (clear),
      .i_wr_req    (wr_req),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .o_wr_ack    (wr_ack),
      .i_rd_req    (rd_req),
      .i_rd_addr   (rd_addr),
      .o_rd_data   (rd_data),
      .o_rd_valid  (rd_valid),
      .o_rec_len   (rec_len),
      .o_sram_addr (sram_addr),
      .o_sram_dq   (sram_dq),
      .o_sram_dq_oe(sram_dq_oe),
      .i_sram_dq   (sram_dq_in),
      .o_sram_we_n (we_n),
      .o_sram_oe_n (oe_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [0:255];
   always @(posedge clk) begin
      if (!we_n) mem[sram_addr[7:0]] <= sram_dq;
   end
   assign sram_dq_in = (!oe_n) ? mem[sram_addr[7:0]] : 16'hDEAD;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns cycles from request to ack (-1 on timeout).
   task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                           output int lat, output int we_low, output int oe_high);
      wr_addr = a;
      wr_data = d;
      wr_req  = 1'b1;
      lat = -1; we_low = 0; oe_high = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!we_n) we_low++;
         if (sram_dq_oe) oe_high++;
         if (wr_ack) begin
            lat = i;
            break;
         end
      end
      wr_req = 1'b0;
   endtask

   task automatic do_read(input logic [19:0] a, output logic [15:0] data,
                          output int lat, output int oe_low);
      rd_addr = a;
      rd_req  = 1'b1;
      lat = -1; oe_low = 0; data = 16'hFFFF;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (!oe_n) oe_low++;
         if (rd_valid) begin
            lat  = i;
            data = rd_data;
            break;
         end
      end
      rd_req = 1'b0;
   endtask

   initial begin
      int          lat;
      int          cnt_a;
      int          cnt_b;
      logic [15:0] data;
      logic [7:0]  seq [0:7];
      int          n;
      int          acks;

      rst = 1'b1; clear = 1'b0;
      wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      rd_req = 1'b0; rd_addr = '0;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_we_n", we_n, 1);
      check("rst_oe_n", oe_n, 1);
      check("rst_dq_oe", sram_dq_oe, 0);
      check("rst_rec_len", rec_len, 0);
      check("rst_ack_valid", {wr_ack, rd_valid}, 0);
      check("rst_addr", sram_addr, 0);

      // Read with nothing recorded returns silence in 2 cycles
      do_read(20'h0, data, lat, cnt_a);
      check("rz0_lat", lat, 2);
      check("rz0_data", data, 16'h0000);
      check("rz0_oe_low", cnt_a, 0);

      // Single write
      @(negedge clk);
      do_write(20'h00010, 16'hBEEF, lat, cnt_a, cnt_b);
      check("wr_lat", lat, 3);
      check("wr_we_low", cnt_a, 2);
      check("wr_dq_oe_cycles", cnt_b, 3);
      check("wr_addr_held", sram_addr, 20'h00010);
      check("wr_dq_held", sram_dq, 16'hBEEF);
      @(negedge clk);
      check("wr_dq_oe_drop", sram_dq_oe, 0);
      check("wr_rec_len", rec_len, 21'h00011);

      // Real read back
      do_read(20'h00010, data, lat, cnt_a);
      check("rd_lat", lat, 3);
      check("rd_data", data, 16'hBEEF);
      check("rd_oe_low", cnt_a, 2);

      // Contention: both requesters held, completions must alternate starting with WR
      @(negedge clk);
      wr_addr = 20'h00005; wr_data = 16'h1234;
      rd_addr = 20'h00010;
      wr_req = 1'b1; rd_req = 1'b1;
      n = 0;
      for (int i = 0; i < 200 && n < 8; i++) begin
         @(negedge clk);
         if (wr_ack) begin seq[n] = 8'h57; n++; end
         if (rd_valid && n < 8) begin seq[n] = 8'h52; n++; end
      end
      wr_req = 1'b0; rd_req = 1'b0;
      check("rr_count", n, 8);
      for (int k = 0; k < 8; k++) begin
         if (k < n) check($sformatf("rr_grant%0d", k), seq[k], (k % 2 == 0) ? 8'h57 : 8'h52);
      end
      @(negedge clk);
      check("rr_rec_len", rec_len, 21'h00011);
      do_read(20'h00005, data, lat, cnt_a);
      check("rd5_data", data, 16'h1234);

      // Beyond recorded length: silence, no SRAM access
      @(negedge clk);
      do_read(20'h00020, data, lat, cnt_a);
      check("rz_lat", lat, 2);
      check("rz_data", data, 16'h0000);
      check("rz_oe_low", cnt_a, 0);
      // Boundary: addr == rec_len is beyond, addr == rec_len-1 is real
      @(negedge clk);
      do_read(20'h00011, data, lat, cnt_a);
      check("rz_edge_oe_low", cnt_a, 0);
      check("rz_edge_lat", lat, 2);
      @(negedge clk);
      do_read(20'h00010, data, lat, cnt_a);
      check("rd_edge_lat", lat, 3);

      // Lower address does not lower the high-water mark
      @(negedge clk);
      do_write(20'h00003, 16'h0303, lat, cnt_a, cnt_b);
      @(negedge clk);
      check("wr_low_rec_len", rec_len, 21'h00011);

      // Clear coinciding with an ack wins
      do_write(20'h00030, 16'h3030, lat, cnt_a, cnt_b);
      check("clr_wr_lat", lat, 3);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_ack_rec_len", rec_len, 0);

      // Write after clear restarts the count
      do_write(20'h00007, 16'h0707, lat, cnt_a, cnt_b);
      @(negedge clk);
      check("clr_wr_rec_len", rec_len, 21'h00008);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clr_rec_len", rec_len, 0);

      // Reset in the 2nd write cycle aborts the write
      wr_addr = 20'h00040; wr_data = 16'h4040; wr_req = 1'b1;
      @(negedge clk);
      check("abort_we_low", we_n, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_we_n", we_n, 1);
      check("abort_dq_oe", sram_dq_oe, 0);
      check("abort_ack", wr_ack, 0);
      rst = 1'b0; wr_req = 1'b0;
      acks = 0;
      repeat (5) begin
         @(negedge clk);
         if (wr_ack) acks++;
      end
      check("abort_no_ack", acks, 0);
      check("abort_rec_len", rec_len, 0);

      // Normal operation resumes after reset
      do_write(20'h00007, 16'h7777, lat, cnt_a, cnt_b);
      check("post_rst_wr_lat", lat, 3);
      @(negedge clk);
      check("post_rst_rec_len", rec_len, 21'h00008);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
